// File: rtl/cell_painter.sv
// cell_painter: fills one rectangular board cell in a frame buffer.
// A start request latches the cell origin and colour, then the block walks
// every pixel of the cell in raster order. It drives one pixel write per
// accepted cycle and skips off-screen pixels without waiting on the write
// port. A one-cycle done pulse marks the end of the fill.
module cell_painter #(
   parameter int CELL_W = 64,
   parameter int CELL_H = 24,
   parameter int SCR_W  = 640,
   parameter int SCR_H  = 480
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       start,
   input  logic [9:0] x0,
   input  logic [8:0] y0,
   input  logic [8:0] color,
   input  logic       wr_ready,
   output logic       busy,
   output logic       done,
   output logic       plot,
   output logic [9:0] px,
   output logic [8:0] py,
   output logic [8:0] pcolor
);

   localparam int CX_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
   localparam int CY_W = (CELL_H > 1) ? $clog2(CELL_H) : 1;

   localparam logic [CX_W-1:0] CX_LAST  = CX_W'(CELL_W - 1);
   localparam logic [CY_W-1:0] CY_LAST  = CY_W'(CELL_H - 1);
   localparam logic [10:0]     SCR_W_L  = 11'(SCR_W);
   localparam logic [9:0]      SCR_H_L  = 10'(SCR_H);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [9:0]        x0_q, x0_d;
   logic [8:0]        y0_q, y0_d;
   logic [8:0]        color_q, color_d;
   logic [CX_W-1:0]   cx_q, cx_d;
   logic [CY_W-1:0]   cy_q, cy_d;

   // Pixel coordinates carry one extra bit so an origin near the top of the
   // 10/9-bit range cannot wrap back onto the visible screen.
   logic [10:0]       sum_x;
   logic [9:0]        sum_y;
   logic              clip;

   // Current pixel address and its on-screen test.
   always_comb begin
      sum_x = {1'b0, x0_q} + 11'(cx_q);
      sum_y = {1'b0, y0_q} + 10'(cy_q);
      clip  = (sum_x >= SCR_W_L) || (sum_y >= SCR_H_L);
   end

   // Next-state, counter and output decode.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path through
      // this block leaves one unassigned, which would infer a latch.
      state_d = state_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      color_d = color_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      busy    = 1'b0;
      done    = 1'b0;
      plot    = 1'b0;
      px      = '0;
      py      = '0;
      pcolor  = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               x0_d    = x0;
               y0_d    = y0;
               color_d = color;
               cx_d    = '0;
               cy_d    = '0;
               state_d = FILL;
            end
         end

         FILL: begin
            busy   = 1'b1;
            px     = sum_x[9:0];
            py     = sum_y[8:0];
            pcolor = color_q;
            plot   = !clip;
            // Clipped pixels never touch the write port, so they need no
            // handshake and move on after a single cycle.
            if (clip || wr_ready) begin
               if (cx_q == CX_LAST) begin
                  cx_d = '0;
                  if (cy_q == CY_LAST) begin
                     state_d = FIN;
                  end else begin
                     cy_d = cy_q + 1'b1;
                  end
               end else begin
                  cx_d = cx_q + 1'b1;
               end
            end
         end

         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // State, latched request and pixel counters.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      // NOTE: every register, latched request data included, is cleared on
      // reset so an aborted fill leaves no stale origin or colour behind.
      if (!resetn) begin
         state_q <= IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         color_q <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // values sampled at the same edge.
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         color_q <= color_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
      end
   end

endmodule

// File: doc/cell_painter.md
CELL_PAINTER -- requirements
Module: cell_painter

Interface
REQ-001 Parameter CELL_W, 64, pixel width of one board cell.
REQ-002 Parameter CELL_H, 24, pixel height of one board cell.
REQ-003 Parameter SCR_W, 640, visible screen width in pixels; pixels at or beyond it are clipped.
REQ-004 Parameter SCR_H, 480, visible screen height in pixels; pixels at or beyond it are clipped.
REQ-005 CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle request to paint one cell.
REQ-008 x0  input  10  top-left pixel X of the cell.
REQ-009 y0  input  9  top-left pixel Y of the cell.
REQ-010 color  input  9  fill colour, RGB 3:3:3.
REQ-011 wr_ready  input  1  frame-buffer write port accepts a pixel this cycle.
REQ-012 busy  output  1  a fill is in progress.
REQ-013 done  output  1  one-cycle pulse when a fill completes.
REQ-014 plot  output  1  pixel write strobe to the frame buffer.
REQ-015 px  output  10  pixel X for the write.
REQ-016 py  output  9  pixel Y for the write.
REQ-017 pcolor  output  9  pixel colour for the write.

Function
REQ-018 The block SHALL be an FSM with three states: IDLE, FILL and FIN.
REQ-019 In IDLE, start=1 SHALL latch x0, y0 and color, clear the offset counters cx and cy, and enter FILL on the next edge.
REQ-020 start SHALL be ignored in FILL and FIN; a request is never queued.
REQ-021 busy SHALL be 1 exactly while the state is FILL.
REQ-022 In FILL, px SHALL equal x0_latched+cx, py SHALL equal y0_latched+cy, and pcolor SHALL equal color_latched.
REQ-023 The sums SHALL be computed one bit wider than px and py.
REQ-024 A pixel SHALL be clipped when its X sum is >= SCR_W or its Y sum is >= SCR_H, including sums that overflow 10 or 9 bits.
REQ-025 For an unclipped pixel, plot SHALL be 1; the pixel advances only in a cycle where plot=1 and wr_ready=1.
REQ-026 For a clipped pixel, plot SHALL be 0 and the pixel SHALL advance unconditionally after one cycle, regardless of wr_ready.
REQ-027 Pixel order SHALL be raster: cx increments first; at cx=CELL_W-1, cx returns to 0 and cy increments.
REQ-028 After pixel (CELL_W-1, CELL_H-1) advances, the FSM SHALL enter FIN.
REQ-029 FIN SHALL last exactly one cycle with done=1, busy=0 and plot=0, then return to IDLE.
REQ-030 Latency, with wr_ready held at 1 and no clipping: start accepted at cycle T; pixels plotted in cycles T+1 through T+CELL_W*CELL_H; done=1 at T+CELL_W*CELL_H+1.
REQ-031 A start asserted in the FIN cycle SHALL be ignored; a start asserted in the following IDLE cycle SHALL be accepted.
REQ-032 plot SHALL be 0 in IDLE and FIN.
REQ-033 Counter widths SHALL hold CELL_W-1 and CELL_H-1 without wrap.
REQ-034 Latched inputs SHALL NOT change during a fill, even if x0, y0 or color change.

Reset
REQ-035 resetn=0 SHALL force state IDLE and set busy, done, plot, px, py, pcolor, cx, cy and all latched registers to 0.
REQ-036 Reset asserted mid-fill SHALL abort the fill immediately, with no further plot and no done pulse.
REQ-037 After reset release, the first accepted start SHALL behave exactly as in REQ-030.

Verification
REQ-038 Basic fill: x0=64, y0=24, color=0x1C7, wr_ready=1, start pulse at T -> 1536 plots covering px 64..127 and py 24..47 in raster order, all with pcolor=0x1C7; done only at T+1537; busy=1 in T+1..T+1536.
REQ-039 Backpressure: same cell, wr_ready toggling 1,0,1,0 -> every pixel plotted exactly once; px/py held while wr_ready=0; done at T+3072.
REQ-040 Clipping: x0=576, y0=468 -> only py 468..479 are plotted (64*12=768 plots); done still after 1536 pixel cycles.
REQ-041 Ignored start: start re-pulsed during FILL and in the FIN cycle with a different x0 -> exactly one fill, for the original cell; a start in the next IDLE cycle begins a new fill.
REQ-042 Reset mid-fill: resetn low after 100 plots -> all outputs 0 immediately, no done; after release, x0=0, y0=0 fill completes normally.
